// File: rtl/fb_cmd_engine.sv
// Framebuffer command engine: decodes 32-bit receiver messages into a stream of
// single-cycle framebuffer writes (pixel, horizontal run, full clear).
module fb_cmd_engine #(
    parameter int COLS = 160,
    parameter int ROWS = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ack,
    output logic        wen,
    output logic [14:0] waddr,
    output logic [7:0]  wdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [1:0] OP_PIXEL = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [6:0] ROW_LAST = 7'(ROWS - 1);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        clear_q, clear_d;
    logic        wen_q, wen_d;
    logic [14:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_q, err_d;

    logic [1:0]  op;
    logic [6:0]  cur_row, nxt_row;
    logic [7:0]  cur_col, nxt_col;
    logic        last_write;

    assign op = in_data[31:30];

    always_comb begin
        cur_row = waddr_q[14:8];
        cur_col = waddr_q[7:0];
        // Out-of-range columns (RUN starting past the edge) wrap like the last column.
        if (cur_col >= COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row >= ROW_LAST) ? '0 : cur_row + 7'd1;
        end else begin
            nxt_col = cur_col + 8'd1;
            nxt_row = cur_row;
        end
        last_write = clear_q ? ((cur_row == ROW_LAST) && (cur_col == COL_LAST))
                             : (cnt_q == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clear_d = clear_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        wen_d   = 1'b1;
                        wdata_d = in_data[7:0];
                        clear_d = (op == OP_CLEAR);
                        cnt_d   = (op == OP_RUN) ? in_data[29:23] : 7'd0;
                        waddr_d = (op == OP_CLEAR) ? 15'd0 : in_data[22:8];
                    end
                end
            end
            WRITE: begin
                if (last_write) begin
                    state_d = IDLE;
                end else begin
                    wen_d   = 1'b1;
                    waddr_d = {nxt_row, nxt_col};
                    cnt_d   = cnt_q - 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clear_q <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign in_ack = (state_q == IDLE) && reset_n;
    assign busy   = (state_q != IDLE);
    assign wen    = wen_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign err    = err_q;

    logic unused_pixel_op;
    assign unused_pixel_op = (op == OP_PIXEL);

endmodule

// File: tb/tb_fb_cmd_engine.sv
// Self-checking bench for fb_cmd_engine: table of single-command vectors plus
// hand-written sequences for held messages, reserved opcodes and mid-clear reset.
module tb_fb_cmd_engine;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ack;
    logic        wen;
    logic [14:0] waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        err;

    fb_cmd_engine #(.COLS(160), .ROWS(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ack  (in_ack),
        .wen     (wen),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [22:0] wq[$];
    int          wc[$];
    int          cyc = 0;
    int          err_n = 0;
    int          err_c = 0;
    int          busy_n = 0;
    int          ack_bad = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            cyc++;
            if (wen) begin
                wq.push_back({waddr, wdata});
                wc.push_back(cyc);
            end
            if (err) begin
                err_n++;
                err_c = cyc;
            end
            if (busy) busy_n++;
            if (busy && in_ack) ack_bad++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clr_mon();
        wq.delete();
        wc.delete();
        err_n  = 0;
        busy_n = 0;
    endtask

    task automatic send(input logic [31:0] d);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        if (i == budget) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] din;
        int          n;
        logic [14:0] first;
        logic [14:0] last;
        logic [7:0]  color;
        int          errs;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{"pixel",       32'h0005_0AFF, 1,     15'h050A, 15'h050A, 8'hFF, 0};
        vt[1] = '{"run_edge",    32'h4182_9E1C, 4,     15'h029E, 15'h0301, 8'h1C, 0};
        vt[2] = '{"run_bottom",  32'h40E3_9F55, 2,     15'h639F, 15'h0000, 8'h55, 0};
        vt[3] = '{"run_max",     32'h7F80_00A5, 128,   15'h0000, 15'h007F, 8'hA5, 0};
        vt[4] = '{"run_offedge", 32'h408A_C811, 2,     15'h0AC8, 15'h0B00, 8'h11, 0};
        vt[5] = '{"reserved",    32'hC012_3456, 0,     15'h0000, 15'h0000, 8'h00, 1};
        vt[6] = '{"clear",       32'hBFFF_FF03, 16000, 15'h0000, 15'h639F, 8'h03, 0};
        vt[7] = '{"pixel_oor",   32'h007F_FF00, 1,     15'h7FFF, 15'h7FFF, 8'h00, 0};

        in_data  = '0;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_wen",    wen,    0);
        chk("rst_busy",   busy,   0);
        chk("rst_err",    err,    0);
        chk("rst_in_ack", in_ack, 0);
        chk("rst_waddr",  waddr,  0);
        chk("rst_wdata",  wdata,  0);
        #18 reset_n = 1'b1;
        #1;
        chk("post_rst_in_ack", in_ack, 1);
        drain();

        for (int v = 0; v < 8; v++) begin
            clr_mon();
            send(vt[v].din);
            wait_idle(20000, vt[v].name);
            drain();
            chk({vt[v].name, "_count"}, wq.size(), vt[v].n);
            chk({vt[v].name, "_busy"},  busy_n,    vt[v].n);
            chk({vt[v].name, "_err"},   err_n,     vt[v].errs);
            if (vt[v].n > 0 && wq.size() == vt[v].n) begin
                chk({vt[v].name, "_first"},  wq[0][22:8],            vt[v].first);
                chk({vt[v].name, "_last"},   wq[vt[v].n-1][22:8],    vt[v].last);
                chk({vt[v].name, "_wdata0"}, wq[0][7:0],             vt[v].color);
                chk({vt[v].name, "_wdataN"}, wq[vt[v].n-1][7:0],     vt[v].color);
                chk({vt[v].name, "_gapless"}, wc[vt[v].n-1] - wc[0] + 1, vt[v].n);
            end
            if (v == 1 && wq.size() == 4) begin
                chk("run_edge_w1", wq[1][22:8], 15'h029F);
                chk("run_edge_w2", wq[2][22:8], 15'h0300);
            end
        end
        chk("ack_while_busy", ack_bad, 0);
        chk("hold_waddr", waddr, 15'h7FFF);

        // CLEAR with a PIXEL held pending on in_valid the whole time.
        begin
            int acks;
            int i;
            acks = 0;
            clr_mon();
            @(negedge clk);
            in_data  = 32'h8000_0003;
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_data = 32'h0005_0AFF;
            for (i = 0; i < 17000; i++) begin
                @(negedge clk);
                #1;
                if (in_ack) begin
                    acks++;
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                    break;
                end
            end
            in_valid = 1'b0;
            wait_idle(100, "held");
            drain();
            chk("held_acks", acks, 1);
            chk("held_count", wq.size(), 16001);
            if (wq.size() == 16001) begin
                chk("held_clear_last", wq[15999], {15'h639F, 8'h03});
                chk("held_pixel",      wq[16000], {15'h050A, 8'hFF});
                chk("held_dead_cycle", wc[16000] - wc[15999], 2);
            end
            chk("held_ack_while_busy", ack_bad, 0);
        end

        // Reserved opcode followed immediately by a PIXEL held on in_valid.
        clr_mon();
        @(negedge clk);
        in_data  = 32'hC000_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_data = 32'h0005_0AFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle(100, "rsvd_b2b");
        drain();
        chk("rsvd_b2b_err",   err_n,     1);
        chk("rsvd_b2b_count", wq.size(), 1);
        if (wq.size() == 1) begin
            chk("rsvd_b2b_pixel", wq[0], {15'h050A, 8'hFF});
            chk("rsvd_b2b_timing", wc[0], err_c + 1);
        end

        // Reset asserted partway through a CLEAR.
        begin
            int i;
            clr_mon();
            send(32'h8000_0003);
            for (i = 0; i < 1000; i++) begin
                @(negedge clk);
                #1;
                if (wq.size() >= 500) break;
            end
            chk("midrst_reached", wq.size(), 500);
            #1 reset_n = 1'b0;
            #1;
            chk("midrst_wen",    wen,    0);
            chk("midrst_busy",   busy,   0);
            chk("midrst_in_ack", in_ack, 0);
            chk("midrst_waddr",  waddr,  0);
            #1 reset_n = 1'b1;
            #1;
            chk("midrst_release_ack", in_ack, 1);
            clr_mon();
            repeat (20) @(negedge clk);
            #1;
            chk("midrst_no_writes", wq.size(), 0);
            chk("midrst_idle",      busy,      0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
